// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: serialises LANES-wide VLDR/VSTR into single-word memory accesses, stalling M.
// Revision 1.0
`default_nettype none

module vector_mem_sequencer #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startM,
  input  logic                        isStoreM,
  input  logic [ADDR_WIDTH-1:0]       baseAddrM,
  input  logic [LANES*DATA_WIDTH-1:0] storeDataM,
  output logic [ADDR_WIDTH-1:0]       memAddr,
  output logic                        memWriteEnable,
  output logic [DATA_WIDTH-1:0]       memWriteData,
  input  logic [DATA_WIDTH-1:0]       memReadData,
  output logic [LANES*DATA_WIDTH-1:0] loadDataOut,
  output logic                        stallOut,
  output logic                        doneOut,
  output logic                        busy
);

  localparam int            C_CW   = $clog2(LANES);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                            r_state;
  state_t                            w_next;
  logic [C_CW-1:0]                   r_cnt;
  logic [ADDR_WIDTH-1:0]             r_base;
  logic [LANES*DATA_WIDTH-1:0]       r_store;
  logic                              r_isStore;
  logic [(LANES-1)*DATA_WIDTH-1:0]   r_gather;
  logic [LANES*DATA_WIDTH-1:0]       r_loadOut;

  // Read data lags its address by one cycle, so lane k-1 is captured while lane k is addressed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_base    <= '0;
      r_store   <= '0;
      r_isStore <= 1'b0;
      r_gather  <= '0;
      r_loadOut <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (startM) begin
            r_base    <= baseAddrM;
            r_store   <= storeDataM;
            r_isStore <= isStoreM;
            r_cnt     <= '0;
          end
        end
        S_ACCESS: begin
          r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + C_CW'(1);
          if (!r_isStore) begin
            for (int i = 0; i < LANES - 1; i++) begin
              if (r_cnt == C_CW'(i + 1))
                r_gather[i*DATA_WIDTH +: DATA_WIDTH] <= memReadData;
            end
          end
        end
        S_DRAIN: r_loadOut <= {memReadData, r_gather};
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    memAddr        = '0;
    memWriteEnable = 1'b0;
    memWriteData   = '0;
    stallOut       = 1'b0;
    doneOut        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (startM) begin
          w_next   = S_ACCESS;
          stallOut = 1'b1;
        end
      end
      S_ACCESS: begin
        stallOut       = 1'b1;
        memAddr        = r_base + ADDR_WIDTH'(r_cnt);
        memWriteEnable = r_isStore;
        if (r_isStore) begin
          for (int i = 0; i < LANES; i++) begin
            if (r_cnt == C_CW'(i))
              memWriteData = r_store[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (r_cnt == C_LAST)
          w_next = r_isStore ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        stallOut = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        doneOut = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign loadDataOut = r_loadOut;

endmodule

`default_nettype wire

// File: doc/vector_mem_sequencer.md
Name:
vector_mem_sequencer

Overview:
- Multi-cycle sequencer for VLDR/VSTR in the M stage of the vector pipeline.
- Data memory is single-port, one lane wide. The block serialises a LANES-wide vector access into one word access per cycle and stalls the pipeline while it runs.
- For VSTR it drives lane-by-lane writes. For VLDR it gathers returned words into a full vector for write-back.
- Triggered by the decoded memory-enable / result-selector controls carried into M.

Parameters:
- LANES, 4, number of vector lanes (power of 2, ≥2).
- DATA_WIDTH, 32, bits per lane and per memory word.
- ADDR_WIDTH, 32, word address width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous active-low reset, sampled on rising clk.
- startM  input  1  VLDR or VSTR present in M stage this cycle.
- isStoreM  input  1  1 = VSTR (writeToMemoryEnableMD path), 0 = VLDR.
- baseAddrM  input  ADDR_WIDTH  word address of lane 0 (scalar ALU result).
- storeDataM  input  LANES*DATA_WIDTH  vector to store; lane i = bits [i*DW +: DW].
- memAddr  output  ADDR_WIDTH  data-memory word address.
- memWriteEnable  output  1  data-memory write strobe.
- memWriteData  output  DATA_WIDTH  data-memory write word.
- memReadData  input  DATA_WIDTH  read word; valid 1 cycle after its address (synchronous RAM).
- loadDataOut  output  LANES*DATA_WIDTH  gathered VLDR vector; held until the next load completes.
- stallOut  output  1  freeze F/D/E/M pipeline registers.
- doneOut  output  1  one-cycle completion pulse.
- busy  output  1  state != IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, DRAIN, DONE.
- Reset (reset=0 at a clk edge, from any state):
  - state=IDLE, lane counter=0.
  - Captured operands cleared; loadDataOut=0.
  - All outputs 0, so memWriteEnable=0 from the following cycle. Any in-flight operation is abandoned with no further writes.
- IDLE:
  - startM=1: capture baseAddrM, storeDataM, isStoreM into registers; counter=0; go to ACCESS.
  - startM=0: stay in IDLE.
- ACCESS, one lane per cycle, lane k = counter:
  - memAddr = baseR + k, modulo 2^ADDR_WIDTH (wrap-around, no error).
  - Store: memWriteEnable=1, memWriteData = lane k of storeR.
  - Load: memWriteEnable=0; address issued for lane k.
  - Counter increments. After lane LANES-1: store goes to DONE, load goes to DRAIN.
- Load capture:
  - Each cycle in ACCESS with k≥1, and in DRAIN, memReadData is written into lane (k-1) of the gather register.
  - DRAIN captures lane LANES-1, then goes to DONE.
- DONE:
  - doneOut=1; for a load, loadDataOut already holds the complete vector.
  - Go to IDLE unconditionally.
  - startM is ignored in DONE, and in ACCESS and DRAIN (operands stay frozen). Under a correct stall it cannot occur.
- In IDLE and DONE: memAddr=0, memWriteEnable=0, memWriteData=0.
- stallOut (combinational) = (IDLE && startM) || ACCESS || DRAIN. It is low in DONE so the pipeline advances that cycle.
- Latency from the startM cycle to doneOut:
  - store: LANES+1 cycles;
  - load: LANES+2 cycles.
- Stall length:
  - store: LANES+1 cycles;
  - load: LANES+2 cycles, counting the IDLE start cycle.
- Back-to-back: the next start is accepted in IDLE, the cycle after DONE. No idle gap is required beyond that.
- A store never modifies loadDataOut.
- Counter width is $clog2(LANES). The final-lane compare uses LANES-1, with no reliance on overflow.

Test Plan (LANES=4, DATA_WIDTH=32):
- VSTR, base=0x100, lanes {0x11,0x22,0x33,0x44}:
  - memWriteEnable high for exactly 4 cycles at addrs 0x100..0x103 with 0x11..0x44 in order.
  - stallOut high 5 cycles; doneOut pulses 5 cycles after start.
- VLDR, base=0x20, memory returning 0xA0+addr:
  - loadDataOut = {0xC3,0xC2,0xC1,0xC0} (lane0=0xC0) when doneOut pulses, 6 cycles after start.
  - memWriteEnable never asserted.
- Wrap-around, VSTR base=0xFFFFFFFE: writes go to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Reset driven low during ACCESS of a store after lane 1:
  - no write for lanes 2–3; next cycle state=IDLE, all outputs 0.
  - A subsequent VLDR completes normally.
- VLDR immediately followed by VSTR (startM in the cycle after doneOut):
  - second op starts with no gap; loadDataOut from the first op is unchanged by the store.
- startM and baseAddrM toggled mid-ACCESS: ignored; addresses and data follow the captured values.
